// File: rtl/pc_flow_ctrl.sv
// Program-flow controller: owns the PC and the {Z,V,N} flag register, resolves
// B/BR against committed flags and runs the RUN/HALT machine.
module pc_flow_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [3:0]  opcode,
  input  logic [2:0]  cond,
  input  logic [8:0]  br_offset,
  input  logic [15:0] br_reg,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        alu_n,
  output logic [15:0] pc,
  output logic [15:0] pc_inc_2,
  output logic [2:0]  flags,
  output logic        taken,
  output logic        halted
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        taken_q, taken_d;
  logic        halted_q;

  logic        commit;
  logic        cond_true;
  logic        flag_z, flag_v, flag_n;
  logic [15:0] br_target;

  assign commit = !stall && (state_q == RUN);
  assign {flag_z, flag_v, flag_n} = flags_q;

  // Conditions use the flags committed on earlier edges, never this cycle's alu_*.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond)
      3'b000: cond_true = !flag_z;
      3'b001: cond_true = flag_z;
      3'b010: cond_true = !flag_z && !flag_n;
      3'b011: cond_true = flag_n;
      3'b100: cond_true = flag_z || !flag_n;
      3'b101: cond_true = flag_z || flag_n;
      3'b110: cond_true = flag_v;
      3'b111: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_inc_2  = pc_q + 16'd2;
  assign br_target = pc_inc_2 + {{6{br_offset[8]}}, br_offset, 1'b0};

  always_comb begin
    pc_d    = pc_inc_2;
    flags_d = flags_q;
    taken_d = 1'b0;
    unique case (opcode)
      OP_ADD, OP_SUB:                 flags_d = {alu_z, alu_v, alu_n};
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d = {alu_z, flags_q[1:0]};
      OP_B: begin
        taken_d = cond_true;
        if (cond_true) pc_d = br_target;
      end
      OP_BR: begin
        taken_d = cond_true;
        if (cond_true) pc_d = br_reg & 16'hFFFE;
      end
      OP_HLT: pc_d = pc_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      flags_q  <= 3'b000;
      taken_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      taken_q <= 1'b0;
      if (commit) begin
        pc_q    <= pc_d;
        flags_q <= flags_d;
        taken_q <= taken_d;
        if (opcode == OP_HLT) begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      end
    end
  end

  assign pc     = pc_q;
  assign flags  = flags_q;
  assign taken  = taken_q;
  assign halted = halted_q;

endmodule

// File: doc/pc_flow_ctrl.md
# pc_flow_ctrl

Sequential program-flow controller for the single-cycle 16-bit processor. It owns the architectural PC register and the Z/V/N flag register. Each cycle it commits the execute-stage ALU flags under per-opcode update rules, resolves B/BR branch conditions against the committed flags, and runs the HLT run/halt state machine. It sits beside the execute stage and replaces the combinational `pc_branch` selection with a registered, stall-aware next-PC path.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-high reset: when rst_n = 1 at a rising clk edge, all state loads its reset value.
- stall  in  1  freeze request; when 1, no state changes.
- opcode  in  4  current instruction opcode (ADD 0000 … HLT 1111).
- cond  in  3  branch condition, instr[11:9].
- br_offset  in  9  B offset, instr[8:0], signed, in halfwords.
- br_reg  in  16  rs value for BR.
- alu_z, alu_v, alu_n  in  1 each  flags computed by execute for the current instruction.
- pc  out  16  registered current PC.
- pc_inc_2  out  16  pc + 2 mod 2^16, combinational from pc.
- flags  out  3  registered {Z,V,N}.
- taken  out  1  registered; 1 for one cycle after a committed taken B/BR.
- halted  out  1  registered; 1 while in HALT.

## Operation
- States: RUN, HALT. Reset → RUN. RUN → HALT on a committed opcode 1111. HALT is left only by reset.
- Commit: a rising edge with rst_n = 0, stall = 0, and state = RUN.
- Flag update on commit:
  - ADD/SUB (0000, 0001): load Z, V, N from alu_*.
  - XOR/SLL/SRA/ROR (0010, 0100, 0101, 0110): load Z only; V and N hold.
  - All other opcodes: flags hold.
- Branch condition, evaluated on the flag register value held before this commit (not alu_*):
  - 000 Z=0
  - 001 Z=1
  - 010 Z=0 & N=0
  - 011 N=1
  - 100 Z=1 | N=0
  - 101 Z=1 | N=1
  - 110 V=1
  - 111 always
- Next PC on commit:
  - B (1100): if cond is true, pc+2+(sext16(br_offset)<<1); otherwise pc+2.
  - BR (1101): if cond is true, br_reg & 16'hFFFE; otherwise pc+2.
  - HLT (1111): pc holds.
  - All others: pc+2.
- All PC arithmetic is 16-bit modulo 2^16. Carries are dropped.
- taken is loaded with (B or BR) & condition-true on each commit. It is loaded with 0 on any non-commit edge, including stall, HALT, and reset.

## Timing
- Reset values: pc = RESET_PC, flags = 3'b000, taken = 0, halted = 0, state = RUN.
- Reset has priority over stall. Reset during HALT or mid-stall returns to RUN the next cycle.
- Latency: pc, flags, taken, and halted update on the edge that commits the instruction; new values are visible in the next cycle.
- pc_inc_2 follows pc with zero cycles of latency.
- Stall: pc, flags, and state hold; taken is forced to 0. Stall in HALT has no effect.
- HALT: pc stays at the HLT address and flags hold. halted = 1 from the cycle after the HLT commit.
- A branch following a flag-setting instruction sees that instruction's flags, because they were committed on the previous edge.
- Wrap-around:
  - pc = 16'hFFFE, non-branch → 16'h0000.
  - B at pc = 16'h0000 with offset 9'h1FF (−1) → 16'h0000.

## Test plan
- Reset and sequencing: hold rst_n = 1 for 2 cycles, then release with RESET_PC = 0 and opcode = ADD. Required: pc = 0000, 0002, 0004 on successive cycles; flags = 000 during reset.
- Flag rules:
  - ADD with alu_z = 0, alu_v = 1, alu_n = 1 → flags = 011.
  - Then XOR with alu_z = 1, alu_v = 0, alu_n = 0 → flags = 111.
  - Then PADDSB with alu_z = 0 → flags remain 111.
- Branches from pc = 0010 with flags Z = 1:
  - B, cond = 001, offset = +4 → pc = 001A, taken = 1.
  - Then B, cond = 000 → pc = 001C, taken = 0.
  - BR, cond = 111, br_reg = 1235 → pc = 1234.
- Stall: assert stall for 3 cycles during a taken B. Required: pc and flags unchanged and taken = 0 throughout; the branch commits on the first unstalled edge.
- HLT: commit HLT at pc = 0040. Required: halted = 1 and pc stays 0040 for 10 cycles regardless of opcode. Then assert rst_n = 1 → pc = 0000, halted = 0.
- Wrap: at pc = FFFE, commit ADD → pc = 0000. At pc = 0000, B, cond = 111, offset = 1FF → pc = 0000.
